// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and byte-lane helper
// for the single-port AHB memory responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Misaligned low bits are dropped here, so sizes above word behave as word.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << lane;
      HSIZE_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Byte-enabled 32-bit word array: synchronous write, combinational read
// from one shared word address.
module ahb_mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // One byte-wide array per lane keeps every array with a single writer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          mem_lane[addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = mem_lane[addr];
    end
  endgenerate

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder with WAIT_STATES wait cycles per data phase.
// Define AHB_MEM_ERR_EN to answer out-of-range or misaligned transfers with ERROR.
module ahb_mem_responder
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg, cnt_next;
  logic                    dp_valid_reg, dp_valid_next;
  logic                    dp_write_reg, dp_write_next;
  logic [ADDR_WIDTH-1:0]   dp_addr_reg, dp_addr_next;
  logic [3:0]              dp_be_reg, dp_be_next;

  logic        hready_int;
  logic        accept;
  logic        addr_err;
  logic        dp_complete;
  logic        mem_we;
  logic [31:0] mem_rdata;

`ifdef AHB_MEM_ERR_EN
  logic misaligned;
  assign misaligned = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE >= HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign addr_err   = (|HADDR[31:ADDR_WIDTH+2]) || misaligned;
`else
  // Upper address bits simply wrap the array in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^HADDR[31:ADDR_WIDTH+2];
  assign addr_err         = 1'b0;
`endif

  assign hready_int  = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign accept      = HSEL && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                       HREADY && hready_int;
  assign dp_complete = dp_valid_reg && (state_reg == ST_IDLE);
  assign mem_we      = dp_complete && dp_write_reg && !RESET;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dp_valid_next = dp_valid_reg;
    dp_write_next = dp_write_reg;
    dp_addr_next  = dp_addr_reg;
    dp_be_next    = dp_be_reg;

    case (state_reg)
      ST_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) begin
          state_next = ST_IDLE;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      ST_ERR2: state_next = ST_IDLE;
      default: ;
    endcase

    if (dp_complete) begin
      dp_valid_next = 1'b0;
    end

    // A new address phase can overlap the completing data phase.
    if (accept) begin
      if (addr_err) begin
        state_next    = ST_ERR1;
        cnt_next      = 3'd0;
        dp_valid_next = 1'b0;
      end else begin
        dp_valid_next = 1'b1;
        dp_write_next = HWRITE;
        dp_addr_next  = HADDR[ADDR_WIDTH+1:2];
        dp_be_next    = lane_mask(HSIZE, HADDR[1:0]);
        if (WAIT_INIT != 3'd0) begin
          state_next = ST_WAIT;
          cnt_next   = WAIT_INIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 3'd0;
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_addr_reg  <= '0;
      dp_be_reg    <= 4'b0000;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dp_valid_reg <= dp_valid_next;
      dp_write_reg <= dp_write_next;
      dp_addr_reg  <= dp_addr_next;
      dp_be_reg    <= dp_be_next;
    end
  end

  ahb_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (CLOCK),
    .we    (mem_we),
    .be    (dp_be_reg),
    .addr  (dp_addr_reg),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HRDATA    = (dp_complete && !dp_write_reg) ? mem_rdata : 32'h0;
  assign HREADYOUT = hready_int;

`ifdef AHB_MEM_ERR_EN
  assign HRESP = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign HRESP = HRESP_OKAY;
`endif

endmodule

// File: doc/ahb_mem_responder.md
AHB_MEM_RESPONDER -- requirements
Module: ahb_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits (array depth 2**ADDR_WIDTH words of 32 bits).
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..7, wait cycles inserted into every valid data phase.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports are listed below.
REQ-004 CLOCK  in  1  rising-edge clock.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 HSEL  in  1  slave select; HADDR  in  32  byte address; HTRANS  in  2  transfer type; HWRITE  in  1  1=write; HSIZE  in  3  transfer size.
REQ-007 HWDATA  in  32  write data, data phase; HREADY  in  1  bus ready (previous transfer complete).
REQ-008 HRDATA  out  32  read data; HREADYOUT  out  1  0=extend data phase; HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-009 Address phase SHALL be accepted only when HSEL=1, HTRANS[1]=1 (NONSEQ or SEQ) and HREADY=1 at a rising edge; HADDR, HWRITE and HSIZE are registered at that edge.
REQ-010 IDLE or BUSY transfers, or HSEL=0, SHALL get a zero-wait OKAY response and SHALL cause no array access.
REQ-011 FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
REQ-012 From IDLE on an accepted valid transfer: go to WAIT with counter=WAIT_STATES if WAIT_STATES>0, otherwise stay in IDLE and complete the data phase in the next cycle.
REQ-013 WAIT SHALL drive HREADYOUT=0 and decrement the counter; at counter=1 it returns to IDLE, so exactly WAIT_STATES low cycles occur before HREADYOUT=1.
REQ-014 A data phase SHALL complete in the cycle where HREADYOUT=1; a new address phase may be accepted in that same cycle.
REQ-015 Write data SHALL be taken from HWDATA in the completing cycle and committed to the array at that edge, using byte lanes from the registered HSIZE/HADDR[1:0] (byte: 1 lane, halfword: 2 lanes, word: 4 lanes).
REQ-016 Read: HRDATA SHALL equal the addressed array word during the completing cycle, and 0 in all other cycles.
REQ-017 A write followed back-to-back by a read of the same address SHALL return the newly written data (array read is combinational from the registered address).
REQ-018 HSIZE>2 SHALL be treated as word.

Reset
REQ-019 RESET SHALL force the state to IDLE, the counter to 0, HREADYOUT=1, HRESP=0 and HRDATA=0, and SHALL clear the pending data phase; array contents are not reset.
REQ-020 RESET asserted during a pending write SHALL abort it with no array update.

Configuration
REQ-021 Macro AHB_MEM_ERR_EN defined: an accepted transfer with HADDR[31:ADDR_WIDTH+2]!=0 or a misaligned address (halfword with HADDR[0]=1, word with HADDR[1:0]!=0) SHALL enter ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE; no wait states; no array write.
REQ-022 Macro AHB_MEM_ERR_EN undefined: upper address bits SHALL be ignored (wrap modulo depth), misaligned low bits SHALL be forced aligned, HRESP SHALL be tied 0, and ERR1/ERR2 SHALL be unreachable.
REQ-023 In ERR2 a new transfer MAY be accepted per REQ-009.

Structure
REQ-024 Package ahb_pkg SHALL hold the HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), the HSIZE codes, the HRESP codes and the FSM state enum.
REQ-025 Sub-module ahb_mem_array SHALL implement the byte-enabled word array (synchronous write, combinational read).

Verification
REQ-026 WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HREADYOUT stays 1; HRDATA=0xDEADBEEF in read data phase.
REQ-027 WAIT_STATES=3: read 0x20 -> exactly 3 cycles HREADYOUT=0, then HREADYOUT=1 with data; HWDATA changes during a write's wait cycles are ignored until completion.
REQ-028 Byte write 0xAA to 0x43 over word 0x11223344 at 0x40 -> read 0x40 returns 0xAA223344.
REQ-029 AHB_MEM_ERR_EN, write to 0x0000_1000 (ADDR_WIDTH=10) -> ERR1 then ERR2, HRESP=1 both cycles; a subsequent read of 0x0 shows the array unchanged.
REQ-030 RESET asserted in the second wait cycle of a write to 0x8 -> HREADYOUT=1 next cycle; a read of 0x8 returns the prior value.
REQ-031 HTRANS=BUSY with HSEL=1, and NONSEQ with HSEL=0 -> OKAY, zero wait, HRDATA=0, no array change.
